// File: rtl/huff_hist_sort.sv
// Frame histogram of symbols 1..NSYM with miss counting, followed by an odd-even
// transposition sort and a ready/valid emission of (symbol, count) in rank order.
module huff_hist_sort #(
   parameter int NSYM = 6,
   parameter int DW   = 8,
   parameter int CW   = 8,
   parameter int SW   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 gray_valid,
   input  logic [DW-1:0]        gray_data,
   output logic                 busy,
   output logic                 cnt_valid,
   output logic [NSYM*CW-1:0]   cnt_flat,
   output logic [CW-1:0]        miss_cnt,
   output logic                 rank_valid,
   input  logic                 rank_ready,
   output logic [SW-1:0]        rank_sym,
   output logic [CW-1:0]        rank_cnt,
   output logic                 rank_last
);

   localparam int IW = (NSYM > 1) ? $clog2(NSYM) : 1;

   typedef enum logic [2:0] {IDLE, RECV, CNT_OUT, SORT, EMIT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q  [NSYM];
   logic [CW-1:0] cnt_d  [NSYM];
   logic [CW-1:0] miss_q, miss_d;
   logic [SW-1:0] tsym_q [NSYM];
   logic [SW-1:0] tsym_d [NSYM];
   logic [CW-1:0] tcnt_q [NSYM];
   logic [CW-1:0] tcnt_d [NSYM];
   // Shared index: pass number while sorting, table entry while emitting.
   logic [IW-1:0] step_q, step_d;
   logic          take;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Higher count first; equal counts fall back to the smaller symbol index.
   function automatic logic ranks_before(input logic [CW-1:0] ca, input logic [SW-1:0] sa,
                                         input logic [CW-1:0] cb, input logic [SW-1:0] sb);
      return (ca > cb) || ((ca == cb) && (sa < sb));
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      miss_d  = miss_q;
      tsym_d  = tsym_q;
      tcnt_d  = tcnt_q;
      step_d  = step_q;
      take    = 1'b0;
      case (state_q)
         IDLE: begin
            if (gray_valid) begin
               state_d = RECV;
               for (int k = 0; k < NSYM; k++) cnt_d[k] = '0;
               miss_d = '0;
               take   = 1'b1;
            end
         end
         RECV: begin
            if (gray_valid) take = 1'b1;
            else            state_d = CNT_OUT;
         end
         CNT_OUT: begin
            state_d = SORT;
            step_d  = '0;
            for (int k = 0; k < NSYM; k++) begin
               tsym_d[k] = SW'(k + 1);
               tcnt_d[k] = cnt_q[k];
            end
         end
         SORT: begin
            for (int i = 0; i < NSYM - 1; i++) begin
               if ((i % 2) == int'(step_q[0])) begin
                  if (ranks_before(tcnt_q[i+1], tsym_q[i+1], tcnt_q[i], tsym_q[i])) begin
                     tsym_d[i]   = tsym_q[i+1];
                     tcnt_d[i]   = tcnt_q[i+1];
                     tsym_d[i+1] = tsym_q[i];
                     tcnt_d[i+1] = tcnt_q[i];
                  end
               end
            end
            if (step_q == IW'(NSYM - 1)) begin
               state_d = EMIT;
               step_d  = '0;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         EMIT: begin
            if (rank_ready) begin
               if (step_q == IW'(NSYM - 1)) begin
                  state_d = IDLE;
                  step_d  = '0;
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (take) begin
         if ((gray_data == '0) || (gray_data > DW'(NSYM))) begin
            miss_d = sat_inc(miss_d);
         end else begin
            for (int k = 0; k < NSYM; k++)
               if (gray_data == DW'(k + 1)) cnt_d[k] = sat_inc(cnt_d[k]);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         miss_q  <= '0;
         step_q  <= '0;
         for (int k = 0; k < NSYM; k++) begin
            cnt_q[k]  <= '0;
            tsym_q[k] <= '0;
            tcnt_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         miss_q  <= miss_d;
         step_q  <= step_d;
         for (int k = 0; k < NSYM; k++) begin
            cnt_q[k]  <= cnt_d[k];
            tsym_q[k] <= tsym_d[k];
            tcnt_q[k] <= tcnt_d[k];
         end
      end
   end

   always_comb begin
      busy       = (state_q != IDLE) && (state_q != RECV);
      cnt_valid  = (state_q == CNT_OUT);
      rank_valid = (state_q == EMIT);
      rank_sym   = rank_valid ? tsym_q[step_q] : '0;
      rank_cnt   = rank_valid ? tcnt_q[step_q] : '0;
      rank_last  = rank_valid && (step_q == IW'(NSYM - 1));
      miss_cnt   = miss_q;
      cnt_flat   = '0;
      for (int k = 0; k < NSYM; k++) cnt_flat[k*CW +: CW] = cnt_q[k];
   end

endmodule

// File: tb/tb_huff_hist_sort.sv
// Directed bench for huff_hist_sort: default, CW=4 and NSYM=8 instances share clock,
// reset, data and rank_ready; each has its own gray_valid.
module tb_huff_hist_sort;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] gd;
   logic [2:0] gvs;
   logic       rr;
   int         sel;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   logic        b0, cv0, rv0, rl0;
   logic [47:0] cf0;
   logic [7:0]  mc0, rc0;
   logic [3:0]  rs0;
   logic        b1, cv1, rv1, rl1;
   logic [23:0] cf1;
   logic [3:0]  mc1, rc1;
   logic [3:0]  rs1;
   logic        b2, cv2, rv2, rl2;
   logic [63:0] cf2;
   logic [7:0]  mc2, rc2;
   logic [3:0]  rs2;

   huff_hist_sort u_def (
      .clk(clk), .reset(reset), .gray_valid(gvs[0]), .gray_data(gd),
      .busy(b0), .cnt_valid(cv0), .cnt_flat(cf0), .miss_cnt(mc0),
      .rank_valid(rv0), .rank_ready(rr), .rank_sym(rs0), .rank_cnt(rc0), .rank_last(rl0));

   huff_hist_sort #(.CW(4)) u_cw4 (
      .clk(clk), .reset(reset), .gray_valid(gvs[1]), .gray_data(gd),
      .busy(b1), .cnt_valid(cv1), .cnt_flat(cf1), .miss_cnt(mc1),
      .rank_valid(rv1), .rank_ready(rr), .rank_sym(rs1), .rank_cnt(rc1), .rank_last(rl1));

   huff_hist_sort #(.NSYM(8), .SW(4)) u_n8 (
      .clk(clk), .reset(reset), .gray_valid(gvs[2]), .gray_data(gd),
      .busy(b2), .cnt_valid(cv2), .cnt_flat(cf2), .miss_cnt(mc2),
      .rank_valid(rv2), .rank_ready(rr), .rank_sym(rs2), .rank_cnt(rc2), .rank_last(rl2));

   logic        bz, cv, rv, rl;
   logic [63:0] cf;
   logic [7:0]  mc, rc;
   logic [3:0]  rs;

   always_comb begin
      bz = b0; cv = cv0; rv = rv0; rl = rl0; cf = {16'b0, cf0}; mc = mc0; rc = rc0; rs = rs0;
      if (sel == 1) begin
         bz = b1; cv = cv1; rv = rv1; rl = rl1; cf = {40'b0, cf1};
         mc = {4'b0, mc1}; rc = {4'b0, rc1}; rs = rs1;
      end else if (sel == 2) begin
         bz = b2; cv = cv2; rv = rv2; rl = rl2; cf = cf2; mc = mc2; rc = rc2; rs = rs2;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input int idx, input int smp[$]);
      for (int i = 0; i < smp.size(); i++) begin
         @(negedge clk);
         gvs[idx] = 1'b1;
         gd       = 8'(smp[i]);
      end
      @(negedge clk);
      gvs = '0;
      gd  = '0;
   endtask

   // Called at the cnt_valid negedge (C+1); rank_valid is expected at C+1+exp_lat.
   task automatic wait_rank(input string tag, input int exp_lat);
      int lat = 0;
      bit got = 0;
      for (int k = 1; k <= 40 && !got; k++) begin
         @(negedge clk);
         if (k == 1) begin
            chk({tag, "_cv_pulse"}, cv, 0);
            chk({tag, "_busy"}, bz, 1);
         end
         if (rv) begin
            got = 1;
            lat = k;
         end
      end
      chk({tag, "_latency"}, lat, exp_lat);
   endtask

   task automatic emit_check(input string tag, input int es[$], input int ec[$]);
      for (int i = 0; i < es.size(); i++) begin
         rr = 1'b1;
         chk($sformatf("%s_rv%0d", tag, i), rv, 1);
         chk($sformatf("%s_sym%0d", tag, i), rs, es[i]);
         chk($sformatf("%s_cnt%0d", tag, i), rc, ec[i]);
         chk($sformatf("%s_last%0d", tag, i), rl, (i == es.size() - 1) ? 1 : 0);
         @(negedge clk);
      end
      rr = 1'b0;
      chk({tag, "_rv_done"}, rv, 0);
      chk({tag, "_idle"}, bz, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int frame[$];
      int es[$];
      int ec[$];
      int seen;
      sel = 0; gvs = '0; gd = '0; rr = 1'b0; reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_busy", bz, 0);
      chk("rst_cv", cv, 0);
      chk("rst_rv", rv, 0);
      chk("rst_cf", cf, 0);
      chk("rst_mc", mc, 0);
      @(negedge clk);
      reset = 1'b1;

      // Reference frame; gray_valid held high through CNT_OUT/SORT must be ignored.
      frame = {1, 1, 2, 3, 3, 3, 6, 5, 5, 5, 5, 4};
      send_frame(0, frame);
      @(negedge clk);
      chk("t1_cv", cv, 1);
      chk("t1_cf", cf, 64'h0000_0104_0103_0102);
      chk("t1_mc", mc, 0);
      gvs[0] = 1'b1; gd = 8'd1;
      wait_rank("t1", 7);
      gvs[0] = 1'b0; gd = '0;
      es = {5, 3, 1, 2, 4, 6}; ec = {4, 3, 2, 1, 1, 1};
      emit_check("t1", es, ec);
      chk("t1_cf_hold", cf, 64'h0000_0104_0103_0102);
      chk("t1_mc_hold", mc, 0);

      // Backpressure on the first entry.
      frame = {2, 2, 1};
      send_frame(0, frame);
      @(negedge clk);
      chk("t2_cf", cf, 64'h0000_0000_0000_0201);
      wait_rank("t2", 7);
      rr = 1'b0;
      for (int s = 0; s < 5; s++) begin
         chk("t2_stall_rv", rv, 1);
         chk("t2_stall_sym", rs, 2);
         chk("t2_stall_cnt", rc, 2);
         chk("t2_stall_last", rl, 0);
         @(negedge clk);
      end
      es = {2, 1, 3, 4, 5, 6}; ec = {2, 1, 0, 0, 0, 0};
      emit_check("t2", es, ec);

      // Out-of-range samples.
      frame = {0, 7, 9, 1};
      send_frame(0, frame);
      @(negedge clk);
      chk("t3_cf", cf, 64'h1);
      chk("t3_mc", mc, 3);
      wait_rank("t3", 7);
      es = {1, 2, 3, 4, 5, 6}; ec = {1, 0, 0, 0, 0, 0};
      emit_check("t3", es, ec);

      // One-sample frame.
      frame = {3};
      send_frame(0, frame);
      @(negedge clk);
      chk("t4_cv", cv, 1);
      chk("t4_cf", cf, 64'h0000_0000_0001_0000);
      wait_rank("t4", 7);
      es = {3, 1, 2, 4, 5, 6}; ec = {1, 0, 0, 0, 0, 0};
      emit_check("t4", es, ec);

      // Reset during SORT aborts the frame.
      frame = {1, 2, 3};
      send_frame(0, frame);
      @(negedge clk);
      chk("t5_cv", cv, 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t5_rst_busy", bz, 0);
      chk("t5_rst_cf", cf, 0);
      chk("t5_rst_rv", rv, 0);
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (rv || bz) seen++;
      end
      chk("t5_no_stale_rank", seen, 0);
      frame = {4, 4};
      send_frame(0, frame);
      @(negedge clk);
      chk("t5_cf", cf, 64'h0000_0000_0200_0000);
      chk("t5_mc", mc, 0);
      wait_rank("t5", 7);
      es = {4, 1, 2, 3, 5, 6}; ec = {2, 0, 0, 0, 0, 0};
      emit_check("t5", es, ec);

      // CW=4 saturation.
      sel = 1;
      frame = {};
      for (int i = 0; i < 20; i++) frame.push_back(2);
      send_frame(1, frame);
      @(negedge clk);
      chk("t6_cv", cv, 1);
      chk("t6_cf", cf, 64'hF0);
      wait_rank("t6", 7);
      es = {2, 1, 3, 4, 5, 6}; ec = {15, 0, 0, 0, 0, 0};
      emit_check("t6", es, ec);

      // NSYM=8, all tied: symbol order, rank_valid at C+10.
      sel = 2;
      frame = {1, 2, 3, 4, 5, 6, 7, 8};
      send_frame(2, frame);
      @(negedge clk);
      chk("t7_cv", cv, 1);
      chk("t7_cf", cf, 64'h0101_0101_0101_0101);
      wait_rank("t7", 9);
      es = {1, 2, 3, 4, 5, 6, 7, 8}; ec = {1, 1, 1, 1, 1, 1, 1, 1};
      emit_check("t7", es, ec);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/huff_hist_sort.md
HUFF_HIST_SORT -- requirements
Module: huff_hist_sort

Interface
REQ-001 Parameter NSYM, default 6: number of counted symbols, values 1..NSYM; legal range 2..16.
REQ-002 Parameter DW, default 8: width of gray_data.
REQ-003 Parameter CW, default 8: width of each occurrence counter.
REQ-004 Parameter SW, default 4: symbol-index width; SHALL satisfy 2^SW > NSYM.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 gray_valid  input  1  qualifies gray_data; a frame is a contiguous run of gray_valid=1.
REQ-008 gray_data  input  DW  symbol sample.
REQ-009 busy  output  1  high in every state except IDLE and RECV.
REQ-010 cnt_valid  output  1  one-cycle strobe: cnt_flat holds the final frame histogram.
REQ-011 cnt_flat  output  NSYM*CW  counters; bits [k*CW +: CW] hold the count of symbol k+1.
REQ-012 miss_cnt  output  CW  count of frame samples outside 1..NSYM.
REQ-013 rank_valid  output  1  ranked entry available.
REQ-014 rank_ready  input  1  downstream accepts the entry when rank_valid=1 and rank_ready=1.
REQ-015 rank_sym  output  SW  symbol of the current ranked entry.
REQ-016 rank_cnt  output  CW  count of the current ranked entry.
REQ-017 rank_last  output  1  high with rank_valid on the NSYM-th (final) entry.

Function
REQ-018 FSM states SHALL be IDLE, RECV, CNT_OUT, SORT, EMIT.
REQ-019 IDLE->RECV when gray_valid=1; on that edge all counters and miss_cnt clear and the first sample is counted.
REQ-020 RECV: each cycle with gray_valid=1 increments the matching counter, or miss_cnt if gray_data is 0 or greater than NSYM; RECV->CNT_OUT on the first cycle with gray_valid=0.
REQ-021 Counters and miss_cnt SHALL saturate at 2^CW-1 and never wrap.
REQ-022 CNT_OUT lasts exactly 1 cycle with cnt_valid=1, then goes to SORT.
REQ-023 SORT loads an NSYM-entry table of (sym, cnt) in symbol order, then runs odd-even transposition passes, one pass per cycle, for exactly NSYM cycles, then goes to EMIT.
REQ-024 Sort order: count descending; on equal counts the smaller symbol index ranks first; the sort is deterministic and total.
REQ-025 EMIT: rank_valid=1 and entry 0 is presented; the entry advances only on a handshake; rank_sym, rank_cnt and rank_last SHALL stay stable while rank_valid=1 and rank_ready=0.
REQ-026 A handshake with rank_last=1 returns the FSM to IDLE with rank_valid=0 on the next cycle.
REQ-027 gray_valid is ignored in CNT_OUT, SORT and EMIT; those samples are not counted and do not start a new frame.
REQ-028 A one-cycle frame is legal: IDLE->RECV->CNT_OUT.
REQ-029 Symbols with count 0 SHALL still be emitted, at the lowest ranks.
REQ-030 cnt_flat and miss_cnt hold their values after CNT_OUT until the next frame starts.
REQ-031 Latency: the gray_valid falling cycle is C; cnt_valid=1 at C+1; rank_valid first rises at C+2+NSYM.

Reset
REQ-032 While reset=0 the FSM SHALL enter IDLE immediately (asynchronously) and clear all counters, miss_cnt, the sort table, cnt_flat and every output to 0, including busy, cnt_valid and rank_valid.
REQ-033 Asserting reset mid-frame, mid-sort or mid-emit SHALL abort the operation; no partial entries are emitted after release.
REQ-034 After reset is released the first rising edge SHALL evaluate IDLE normally.

Verification
REQ-035 Defaults, frame 1,1,2,3,3,3,6,5,5,5,5,4 -> cnt_valid once with counts 2,1,3,1,4,1; ranks (5,4),(3,3),(1,2),(2,1),(4,1),(6,1); rank_last on the sixth entry.
REQ-036 CW=4, 20 samples of symbol 2 -> count of symbol 2 reads 15 (saturated); symbol 2 is ranked first.
REQ-037 Frame 0,7,9,1 -> miss_cnt=3; count of symbol 1 is 1; symbols 2..6 are emitted with count 0 in order 2,3,4,5,6.
REQ-038 rank_ready held 0 for 5 cycles during EMIT -> outputs stay stable; exactly NSYM handshakes occur in total; the FSM returns to IDLE.
REQ-039 reset driven 0 during SORT, then a new frame 4,4 -> no rank_valid from the aborted frame; the new histogram shows only symbol 4 = 2.
REQ-040 NSYM=8, SW=4, frame of all symbols once -> ranks follow symbol order 1..8 under the tie rule; rank_valid first rises at C+10.
